video_sync_ctrl: RTL and testbench
==================================

# video_sync_ctrl

Sequences re-synchronisation of the HDMI output path to the Atari ST video stream. It measures line length and frame height from `hs`/`vs`, qualifies the timing as stable over several frames, and classifies the video mode. It then issues one `vreset` pulse at a fixed active-video position to re-align the HDMI generator, and reports lock status. It sits between the ST shifter sync outputs and the HDMI timing generator, replacing free-running reset generation with a qualified lock sequence.

## Interface
- `HRESET_POS`, 160: `hcnt` value at which `vreset` fires.
- `VRESET_LINE`, 28: `vcnt` value at which `vreset` fires.
- `STABLE_FRAMES`, 4: consecutive matching frames required before arming.
- `TIMEOUT`, 8191: cycles without an `hs` falling edge before returning to SEARCH.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `hs` in 1: horizontal sync, active low; synchronous to `clk`.
- `vs` in 1: vertical sync, active low; synchronous to `clk`.
- `de` in 1: display enable; ignored except by the `de_seen` flag.
- `vreset` out 1: one-cycle re-sync pulse to the HDMI generator.
- `locked` out 1: timing qualified and `vreset` issued.
- `mode` out 2: 0 unknown, 1 PAL 50 Hz, 2 NTSC 60 Hz, 3 mono 71 Hz.
- `line_len` out 13: last measured line length in clk cycles.
- `frame_lines` out 10: last measured frame height in lines.
- `de_seen` out 1: `de` was high at least once in the last complete frame.

## Operation
- Edge detect:
  - `hsD` and `vsD` are registered copies.
  - `hs_fall = hsD & ~hs`.
  - `vs` is sampled into `vsD` only on `hs_fall`; `vs_fall` is evaluated on `hs_fall` cycles as `vsD & ~vs`.
- `hcnt` (13 b):
  - 0 on the `hs_fall` cycle, otherwise +1, saturating at 8191.
  - On `hs_fall`: `line_len <= hcnt+1`.
  - `line_mis` is set if the new value differs from the previous `line_len` and `first_line` is clear. `first_line` is cleared on that capture.
- `vcnt` (10 b):
  - On `hs_fall`: 0 if `vs_fall`, else +1, saturating at 1023.
  - On `vs_fall`: `frame_lines <= vcnt+1`.
  - On `vs_fall`: `de_seen <=` the frame-accumulated `de` OR, and the accumulator clears.
- Timeout: `hcnt` reaching `TIMEOUT` forces SEARCH from any state.
- FSM states: SEARCH, MEASURE, ARM, LOCKED.
  - SEARCH:
    - `locked=0`, `mode=0`, `first_line=1`, stable count 0, `ref_lines=0`.
    - First `vs_fall` -> MEASURE.
  - MEASURE, on each `vs_fall`:
    - If `vcnt+1 == ref_lines` and `!line_mis`: stable count +1.
    - Otherwise: stable count 0 and `ref_lines <= vcnt+1`.
    - `line_mis` clears on every `vs_fall`.
    - When the count reaches `STABLE_FRAMES` -> ARM.
  - ARM:
    - On the cycle with `hcnt==HRESET_POS && vcnt==VRESET_LINE`: `vreset <= 1` for exactly one cycle and go to LOCKED.
    - `mode` is latched from `ref_lines`: 300..330 -> 1, 250..280 -> 2, 490..510 -> 3, else 0.
    - A `line_mis` or a frame-height mismatch while in ARM returns to MEASURE with count 0.
  - LOCKED:
    - `locked=1`.
    - Any `line_mis`, or a `vs_fall` with `vcnt+1 != ref_lines`, -> MEASURE. The stable count becomes 0 and `ref_lines` takes the new value.
    - `locked` and `mode` drop on the transition.
    - No further `vreset` is issued while LOCKED.
- Simultaneous events:
  - Timeout has priority over all other transitions.
  - A mismatch in the same cycle as the ARM fire position suppresses `vreset`.

## Timing
- Reset values: `vreset=0`, `locked=0`, `mode=0`, `line_len=0`, `frame_lines=0`, `de_seen=0`, state SEARCH, counters 0.
- Asserting `reset` mid-operation clears everything immediately, including a `vreset` pulse in progress.
- All outputs are registered.
- `vreset` rises on the clock edge after the internal counters equal (`HRESET_POS`, `VRESET_LINE`).
- `locked` rises on the same edge as `vreset`.
- `line_len` updates on the edge following the `hs_fall` cycle; `frame_lines` on the edge following the `vs_fall` cycle.
- `locked` drops one cycle after the `hs_fall` that detects a mismatch.
- Minimum lock time from the first `vs_fall` is `STABLE_FRAMES+1` frames, plus the arm delay within the next frame.

## Test plan
- PAL stream, 512-clk lines, 313-line frames:
  - `frame_lines=313` and `line_len=512`.
  - `vs_fall` #6 enters ARM.
  - A single `vreset` pulse occurs at line 28, `hcnt` 160 of the next frame.
  - `locked=1`, `mode=1`.
- Locked PAL, then switch to 501-line / 448-clk mono frames:
  - `locked` drops at the first differing line.
  - Relock occurs after 4 matching frames with `mode=3` and exactly one new `vreset`.
- Locked stream with a single 511-clk line injected:
  - `locked` drops.
  - The stable count restarts from 0.
  - `vreset` fires again only after re-qualification.
- Stop `hs` (hold high) for 9000 cycles: state returns to SEARCH, `locked=0`, `mode=0`, and `vreset` stays low.
- Assert `reset` during ARM one cycle before the fire position: no `vreset`, all outputs at their reset values, and normal lock from scratch afterwards.
- 263-line NTSC frames with `de` held low: `mode=2` on lock and `de_seen=0`. With `de` pulsed once per frame, `de_seen=1`.

Source files
------------

// File: rtl/video_sync_ctrl.sv
// video_sync_ctrl: measures the line length and frame height of the ST sync
// stream and checks that the timing stays the same for several frames. It then
// sends one vreset pulse to re-align the HDMI timing generator and reports lock
// status and the detected video mode.
module video_sync_ctrl #(
    parameter int HRESET_POS    = 160,
    parameter int VRESET_LINE   = 28,
    parameter int STABLE_FRAMES = 4,
    parameter int TIMEOUT       = 8191
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    output logic        vreset,
    output logic        locked,
    output logic [1:0]  mode,
    output logic [12:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        de_seen
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        ARM     = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int              SW       = $clog2(STABLE_FRAMES + 1);
    localparam logic [12:0]     HPOS     = 13'(HRESET_POS);
    localparam logic [9:0]      VPOS     = 10'(VRESET_LINE);
    localparam logic [12:0]     TMO      = 13'(TIMEOUT);
    localparam logic [SW-1:0]   STABLE_N = SW'(STABLE_FRAMES);

    // Mode from the qualified frame height.
    function automatic logic [1:0] classify(input logic [9:0] lines);
        if (lines >= 10'd300 && lines <= 10'd330) return 2'd1;
        if (lines >= 10'd250 && lines <= 10'd280) return 2'd2;
        if (lines >= 10'd490 && lines <= 10'd510) return 2'd3;
        return 2'd0;
    endfunction

    state_t        state, state_n;
    logic          hs_d, vs_d;
    logic [12:0]   hcnt;
    logic [9:0]    vcnt;
    logic          first_line, line_mis, de_acc;
    logic [SW-1:0] stable_cnt, cnt_n;
    logic [9:0]    ref_lines, ref_n;
    logic          vreset_n, locked_n;
    logic [1:0]    mode_n;

    logic          hs_fall, vs_fall, new_mis, frame_ok, timeout, fire;
    logic [12:0]   hcnt_inc;
    logic [9:0]    vcnt_inc;

    // vs only counts as falling when sampled on a line start, so a vs edge in
    // the middle of a line does not start a new frame.
    assign hs_fall  = hs_d & ~hs;
    assign vs_fall  = hs_fall & vs_d & ~vs;
    assign hcnt_inc = (hcnt == 13'h1FFF) ? hcnt : hcnt + 13'd1;
    assign vcnt_inc = (vcnt == 10'h3FF)  ? vcnt : vcnt + 10'd1;
    assign new_mis  = hs_fall & ~first_line & (hcnt_inc != line_len);
    assign frame_ok = (vcnt_inc == ref_lines);
    assign timeout  = (hcnt >= TMO);
    assign fire     = (hcnt == HPOS) && (vcnt == VPOS);

    // Sync edge history and the horizontal/vertical position counters.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            hs_d <= 1'b0;
            vs_d <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hs_d <= hs;
            hcnt <= hs_fall ? 13'd0 : hcnt_inc;
            if (hs_fall) begin
                vs_d <= vs;
                vcnt <= vs_fall ? 10'd0 : vcnt_inc;
            end
        end
    end

    // Line/frame measurements, line-length mismatch tracking and de activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_len    <= '0;
            frame_lines <= '0;
            de_seen     <= 1'b0;
            de_acc      <= 1'b0;
            first_line  <= 1'b1;
            line_mis    <= 1'b0;
        end else begin
            if (hs_fall) line_len <= hcnt_inc;
            if (vs_fall) begin
                frame_lines <= vcnt_inc;
                de_seen     <= de_acc;
                de_acc      <= de;
            end else begin
                de_acc <= de_acc | de;
            end
            // The first captured line after SEARCH has nothing valid to compare with.
            if (state == SEARCH) first_line <= 1'b1;
            else if (hs_fall)    first_line <= 1'b0;
            // Sticky only while measuring; ARM and LOCKED react to new_mis directly.
            if (state == MEASURE && !vs_fall) line_mis <= line_mis | new_mis;
            else                              line_mis <= 1'b0;
        end
    end

    // Lock sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            stable_cnt <= '0;
            ref_lines  <= '0;
            vreset     <= 1'b0;
            locked     <= 1'b0;
            mode       <= 2'd0;
        end else begin
            state      <= state_n;
            stable_cnt <= cnt_n;
            ref_lines  <= ref_n;
            vreset     <= vreset_n;
            locked     <= locked_n;
            mode       <= mode_n;
        end
    end

    // Next-state and next-output decode; timeout overrides every other transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves one unassigned and infers a latch.
        state_n  = state;
        cnt_n    = stable_cnt;
        ref_n    = ref_lines;
        vreset_n = 1'b0;
        locked_n = locked;
        mode_n   = mode;

        unique case (state)
            SEARCH: begin
                locked_n = 1'b0;
                mode_n   = 2'd0;
                cnt_n    = '0;
                ref_n    = '0;
                if (vs_fall) state_n = MEASURE;
            end
            MEASURE: begin
                locked_n = 1'b0;
                if (vs_fall) begin
                    if (frame_ok && !(line_mis || new_mis)) begin
                        cnt_n = stable_cnt + 1'b1;
                        if (cnt_n == STABLE_N) state_n = ARM;
                    end else begin
                        cnt_n = '0;
                        ref_n = vcnt_inc;
                    end
                end
            end
            ARM, LOCKED: begin
                if (new_mis || (vs_fall && !frame_ok)) begin
                    state_n  = MEASURE;
                    cnt_n    = '0;
                    locked_n = 1'b0;
                    mode_n   = 2'd0;
                    if (vs_fall) ref_n = vcnt_inc;
                end else if (state == ARM && fire) begin
                    state_n  = LOCKED;
                    vreset_n = 1'b1;
                    locked_n = 1'b1;
                    mode_n   = classify(ref_lines);
                end
            end
            default: state_n = SEARCH;
        endcase

        if (timeout) begin
            state_n  = SEARCH;
            cnt_n    = '0;
            ref_n    = '0;
            vreset_n = 1'b0;
            locked_n = 1'b0;
            mode_n   = 2'd0;
        end
    end

endmodule

// File: tb/tb_video_sync_ctrl.sv
// Directed bench for video_sync_ctrl. Lines are shortened (5-6 clocks) and
// HRESET_POS is set to 2 so that full 263..501-line frames still run quickly;
// the line counts, and therefore the mode classification, are the real ones.
// Each line starts with a single-cycle hs low; vs is low for lines 0..2.
module tb_video_sync_ctrl;

    logic        clk, reset, hs, vs, de;
    logic        vreset, locked, de_seen;
    logic [1:0]  mode;
    logic [12:0] line_len;
    logic [9:0]  frame_lines;

    int n_cmp = 0;
    int n_err = 0;
    int gen_line, gen_pix;
    int vr_count = 0, vr_line = -1, vr_pix = -1;
    int drop_line = -1, drop_pix = -1;
    logic locked_q = 1'b0;

    video_sync_ctrl #(
        .HRESET_POS   (2),
        .VRESET_LINE  (28),
        .STABLE_FRAMES(4),
        .TIMEOUT      (8191)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .vreset     (vreset),
        .locked     (locked),
        .mode       (mode),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .de_seen    (de_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every vreset cycle and every falling edge of locked with the
    // generator position of the cycle in which it is visible.
    always @(negedge clk) begin
        if (vreset === 1'b1) begin
            vr_count = vr_count + 1;
            vr_line  = gen_line;
            vr_pix   = gen_pix;
        end
        if (locked_q === 1'b1 && locked === 1'b0) begin
            drop_line = gen_line;
            drop_pix  = gen_pix;
        end
        locked_q = locked;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vreset"},      32'(vreset),      0);
        check({tag, "_locked"},      32'(locked),      0);
        check({tag, "_mode"},        32'(mode),        0);
        check({tag, "_line_len"},    32'(line_len),    0);
        check({tag, "_frame_lines"}, 32'(frame_lines), 0);
        check({tag, "_de_seen"},     32'(de_seen),     0);
    endtask

    task automatic drive_pix(input int line, input int pix, input bit de_pulse);
        gen_line = line;
        gen_pix  = pix;
        hs = (pix == 0) ? 1'b0 : 1'b1;
        vs = (line < 3) ? 1'b0 : 1'b1;
        de = (de_pulse && line == 10 && pix == 1) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            gen_line = -1;
            gen_pix  = i;
            hs = 1'b1;
            vs = 1'b1;
            de = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_lines(input int first, input int last, input int len,
                             input int short_line, input bit de_pulse);
        for (int l = first; l <= last; l++) begin
            int ll;
            ll = (l == short_line) ? len - 1 : len;
            for (int p = 0; p < ll; p++) drive_pix(l, p, de_pulse);
        end
    endtask

    task automatic run_frames(input int n, input int nlines, input int len, input bit de_pulse);
        for (int f = 0; f < n; f++) run_lines(0, nlines - 1, len, -1, de_pulse);
    endtask

    initial begin
        reset = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b0;
        gen_line = -1; gen_pix = -1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        idle(4);

        // PAL 313 lines: six frames reach ARM (vs_fall #6), lock in the seventh.
        run_frames(6, 313, 5, 1'b1);
        check("pal_frame_lines", 32'(frame_lines), 313);
        check("pal_line_len",    32'(line_len),    5);
        check("pal_arm_unlocked", 32'(locked),     0);
        check("pal_no_early_vreset", 32'(vr_count), 0);
        run_frames(1, 313, 5, 1'b1);
        check("pal_locked",  32'(locked),  1);
        check("pal_mode",    32'(mode),    1);
        check("pal_vreset_count", 32'(vr_count), 1);
        check("pal_vreset_line",  32'(vr_line),  28);
        check("pal_vreset_pix",   32'(vr_pix),   4);

        // One short line (line 100) inside a locked PAL frame.
        run_lines(0, 312, 5, 100, 1'b1);
        check("inj_unlocked",  32'(locked),    0);
        check("inj_mode",      32'(mode),      0);
        check("inj_drop_line", 32'(drop_line), 101);
        check("inj_drop_pix",  32'(drop_pix),  1);
        run_frames(4, 313, 5, 1'b1);
        check("inj_requalifying", 32'(locked),   0);
        check("inj_no_vreset",    32'(vr_count), 1);
        run_frames(1, 313, 5, 1'b1);
        check("inj_relocked",     32'(locked),   1);
        check("inj_vreset_count", 32'(vr_count), 2);

        // Switch to 501-line mono frames with longer lines.
        run_frames(1, 501, 6, 1'b1);
        check("mono_unlocked",  32'(locked),    0);
        check("mono_drop_line", 32'(drop_line), 1);
        check("mono_drop_pix",  32'(drop_pix),  1);
        run_frames(4, 501, 6, 1'b1);
        check("mono_frame_lines", 32'(frame_lines), 501);
        check("mono_line_len",    32'(line_len),    6);
        check("mono_not_yet",     32'(locked),      0);
        run_frames(1, 501, 6, 1'b1);
        check("mono_locked",       32'(locked),   1);
        check("mono_mode",         32'(mode),     3);
        check("mono_vreset_count", 32'(vr_count), 3);
        check("mono_vreset_line",  32'(vr_line),  28);
        check("mono_vreset_pix",   32'(vr_pix),   4);

        // hs stops: still locked shortly after, back in SEARCH after 9000 cycles.
        idle(100);
        check("to_still_locked", 32'(locked), 1);
        idle(8900);
        check("to_locked",       32'(locked),   0);
        check("to_mode",         32'(mode),     0);
        check("to_vreset_count", 32'(vr_count), 3);

        // NTSC 263 lines, de low: full qualification from SEARCH again.
        run_frames(6, 263, 5, 1'b0);
        check("ntsc_not_yet", 32'(locked), 0);
        run_frames(1, 263, 5, 1'b0);
        check("ntsc_locked",       32'(locked),      1);
        check("ntsc_mode",         32'(mode),        2);
        check("ntsc_frame_lines",  32'(frame_lines), 263);
        check("ntsc_de_seen_low",  32'(de_seen),     0);
        check("ntsc_vreset_count", 32'(vr_count),    4);
        run_frames(2, 263, 5, 1'b1);
        check("ntsc_de_seen_high", 32'(de_seen),  1);
        check("ntsc_stays_locked", 32'(locked),   1);
        check("ntsc_one_vreset",   32'(vr_count), 4);

        // Reset during ARM one cycle before the fire position.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        run_frames(6, 263, 5, 1'b1);
        run_lines(0, 27, 5, -1, 1'b1);
        drive_pix(28, 0, 1'b1);
        drive_pix(28, 1, 1'b1);
        check("arm_before_reset", 32'(locked), 0);
        reset = 1'b1;
        drive_pix(28, 2, 1'b1);
        drive_pix(28, 3, 1'b1);
        check_reset_outputs("arm_rst");
        drive_pix(28, 4, 1'b1);
        reset = 1'b0;
        check("arm_rst_no_vreset", 32'(vr_count), 4);
        run_lines(29, 262, 5, -1, 1'b1);
        run_frames(5, 263, 5, 1'b1);
        check("rst_relock_not_yet", 32'(locked), 0);
        run_frames(1, 263, 5, 1'b1);
        check("rst_relocked",     32'(locked),   1);
        check("rst_mode",         32'(mode),     2);
        check("rst_vreset_count", 32'(vr_count), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
